chess_cursor_ctrl: RTL
======================

// Module: chess_cursor_ctrl
// PURPOSE
//  Sequences user interaction with the 8x8 VGA chessboard: debounces five push-buttons.
//  Moves a cursor tile and runs a pick/place FSM that emits one move command per selection.
//  Updates are applied only on the frame_tick pulse from the VGA timing generator, so the renderer never tears mid-frame.
//  Sits between board I/O and the chessboard renderer / move logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable cycles before a button change is accepted (10 ms @ 25.175 MHz); min 2
//  CUR_INIT_X       4       cursor file (0-7) after reset
//  CUR_INIT_Y       6       cursor rank (0-7) after reset
// PORTS
//  clk         in   1  pixel clock, all logic on rising edge
//  rst_n       in   1  synchronous reset, active low
//  btn_up      in   1  raw async button, active high (y-1)
//  btn_down    in   1  raw async button, active high (y+1)
//  btn_left    in   1  raw async button, active high (x-1)
//  btn_right   in   1  raw async button, active high (x+1)
//  btn_sel     in   1  raw async button, active high (pick/place)
//  frame_tick  in   1  1-cycle pulse at start of vertical blank
//  cur_x       out  3  cursor file
//  cur_y       out  3  cursor rank
//  src_valid   out  1  a source square is currently picked
//  src_x       out  3  picked source file (valid when src_valid)
//  src_y       out  3  picked source rank
//  move_valid  out  1  1-cycle pulse: move command issued
//  move_from   out  6  {src_y,src_x} of the move
//  move_to     out  6  {cur_y,cur_x} of the move
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): cur_x=CUR_INIT_X, cur_y=CUR_INIT_Y, src_valid=0, src_x/src_y=0, move_valid=0, move_from/move_to=0.
//    Also clears sync flops, debounce counters/stable states and all pending bits.
//    Reset mid-debounce or with events pending discards them.
//  - Input path per button: 2-FF synchronizer -> debouncer.
//    Stable state flips only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle zeroes the counter.
//  - Press event = stable 0->1. Each event sets a sticky pending bit. Repeated presses before the next frame_tick coalesce into one. Releases are ignored.
//  - Apply: on a cycle with frame_tick=1, all pending bits are consumed and results are registered at that edge (visible next cycle).
//    An event detected in the same cycle as frame_tick stays pending for the following tick.
//  - Simultaneous events: up+down pending together cancel (no y change); left+right likewise cancel for x.
//    Orthogonal pairs apply together (diagonal step).
//  - Edges: without CURSOR_WRAP_EN the cursor saturates at 0 and 7.
//  - Select is evaluated after movement, against the NEW cursor position, in the same tick.
//  - FSM (state == src_valid):
//      IDLE   --sel--> PICKED : src_x/src_y <= new cursor.
//      PICKED --sel, new cursor == src--> IDLE : deselect, no move.
//      PICKED --sel, new cursor != src--> IDLE : move_valid=1 for exactly one cycle, move_from={src_y,src_x}, move_to={new cur_y,cur_x}.
//  - Output hold: move_from/move_to hold their last value after the pulse. src_x/src_y hold after deselect.
//  - Latency: press stable at pins -> pending after 2+DEBOUNCE_CYCLES+1 cycles -> outputs one cycle after the next frame_tick.
//  - frame_tick held high several cycles: only the first cycle with pending bits has effect (bits already cleared).
// CONFIGURATION
//  CURSOR_WRAP_EN defined: cursor moves modulo 8, so x=7 +right -> 0 and y=0 +up -> 7; cancel rules unchanged.
//  CURSOR_WRAP_EN undefined: saturating movement, so x=7 +right stays 7 and y=0 +up stays 0.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  1 Reset: hold rst_n=0 with all buttons high, release.
//    -> cur=(4,6), src_valid=0, move_valid=0; no pending events survive, so no change on first frame_tick.
//  2 Debounce: btn_right glitches 3 cycles high, then stays high for 10; tick.
//    -> glitch ignored; cur_x 4->5 exactly once after the tick.
//    -> 3 presses before one tick still give cur_x=5.
//  3 Move: from (4,6) press sel, tick -> src_valid=1, src=(4,6).
//    Press up twice (two ticks) -> cur=(4,4).
//    Press sel, tick -> move_valid 1 cycle, move_from=6'o64, move_to=6'o44, src_valid=0.
//  4 Deselect and same-tick ordering: pick at (2,2); press sel on same square -> src_valid=0, no pulse.
//    Then pick at (2,2) and press right+sel before one tick -> move_to=(3,2).
//  5 Edges/cancel: at (7,0) press right+up, tick.
//    -> saturate (7,0) without macro; (0,7) with CURSOR_WRAP_EN.
//    -> up+down pending together leaves cur_y unchanged.
//  6 Timing: event detected in the same cycle as frame_tick -> no change that frame; applied on the next tick.
//    Reset asserted while src_valid=1 -> src_valid=0, no move_valid.

Source files
------------

// File: rtl/chess_cursor_ctrl.sv
// chess_cursor_ctrl: debounced cursor movement and pick/place move sequencing, applied per frame_tick.
// Define CURSOR_WRAP_EN for modulo-8 cursor movement; the default build saturates at the board edges.
module chess_cursor_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter logic [2:0] CUR_INIT_X      = 3'd4,
    parameter logic [2:0] CUR_INIT_Y      = 3'd6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic       frame_tick,
    output logic [2:0] cur_x,
    output logic [2:0] cur_y,
    output logic       src_valid,
    output logic [2:0] src_x,
    output logic [2:0] src_y,
    output logic       move_valid,
    output logic [5:0] move_from,
    output logic [5:0] move_to
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {IDLE, PICKED} state_t;

    state_t        state;
    logic [4:0]    btn, s1, s2, stable, stable_q, evt, pend;
    logic [CW-1:0] cnt [5];
    logic          up, dn, lf, rt, sel;
    logic [2:0]    nx, ny;

    assign btn = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign evt = stable & ~stable_q;
    assign {sel, rt, lf, dn, up} = pend;
    assign src_valid = (state == PICKED);

`ifdef CURSOR_WRAP_EN
    assign nx = (rt && !lf) ? cur_x + 3'd1 : (lf && !rt) ? cur_x - 3'd1 : cur_x;
    assign ny = (dn && !up) ? cur_y + 3'd1 : (up && !dn) ? cur_y - 3'd1 : cur_y;
`else
    assign nx = (rt && !lf && cur_x != 3'd7) ? cur_x + 3'd1 : (lf && !rt && cur_x != 3'd0) ? cur_x - 3'd1 : cur_x;
    assign ny = (dn && !up && cur_y != 3'd7) ? cur_y + 3'd1 : (up && !dn && cur_y != 3'd0) ? cur_y - 3'd1 : cur_y;
`endif

    // Synchronize, debounce, and latch press events until the next frame tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_q <= '0;
            pend     <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            stable_q <= stable;
            pend     <= frame_tick ? evt : (pend | evt);
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]    <= '0;
                    stable[i] <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Select acts on the post-movement cursor of the same tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_x      <= CUR_INIT_X;
            cur_y      <= CUR_INIT_Y;
            src_x      <= '0;
            src_y      <= '0;
            move_valid <= 1'b0;
            move_from  <= '0;
            move_to    <= '0;
        end else begin
            move_valid <= 1'b0;
            if (frame_tick) begin
                cur_x <= nx;
                cur_y <= ny;
                if (sel) begin
                    if (state == IDLE) begin
                        state <= PICKED;
                        src_x <= nx;
                        src_y <= ny;
                    end else begin
                        state <= IDLE;
                        if ({ny, nx} != {src_y, src_x}) begin
                            move_valid <= 1'b1;
                            move_from  <= {src_y, src_x};
                            move_to    <= {ny, nx};
                        end
                    end
                end
            end
        end
    end
endmodule
